// File: rtl/tq_idct_4x4_seq_if.sv
// Row-in / column-out handshake bundle for the 4x4 inverse core transform.
// The master drives rows and the output ready; the slave (transform) drives everything else.
interface tq_idct_4x4_seq_if #(
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned RES_WIDTH  = 9
);
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic signed [COEF_WIDTH-1:0] in_c0_i;
  logic signed [COEF_WIDTH-1:0] in_c1_i;
  logic signed [COEF_WIDTH-1:0] in_c2_i;
  logic signed [COEF_WIDTH-1:0] in_c3_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [1:0]                  out_col_o;
  logic signed [RES_WIDTH-1:0]  out_r0_o;
  logic signed [RES_WIDTH-1:0]  out_r1_o;
  logic signed [RES_WIDTH-1:0]  out_r2_o;
  logic signed [RES_WIDTH-1:0]  out_r3_o;

  modport master (
    output in_valid_i, in_c0_i, in_c1_i, in_c2_i, in_c3_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_col_o, out_r0_o, out_r1_o, out_r2_o, out_r3_o
  );

  modport slave (
    input  in_valid_i, in_c0_i, in_c1_i, in_c2_i, in_c3_i, out_ready_i,
    output in_ready_o, out_valid_o, out_col_o, out_r0_o, out_r1_o, out_r2_o, out_r3_o
  );
endinterface

// File: rtl/tq_idct_4x4_seq.sv
// Sequential H.264-style 4x4 inverse core transform: horizontal pass on row entry,
// vertical pass plus rounding/saturation on column exit, single block buffer.
module tq_idct_4x4_seq #(
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned RES_WIDTH  = 9
) (
  input logic              clk,
  input logic              rst_n,
  input logic              clear_i,
  tq_idct_4x4_seq_if.slave bus
);

  localparam int unsigned HW    = COEF_WIDTH + 2;
  localparam int unsigned VW    = COEF_WIDTH + 5;
  localparam int unsigned EXT_C = HW - COEF_WIDTH;
  localparam int unsigned EXT_H = VW - HW;

  typedef logic signed [HW-1:0]        hor_t;
  typedef logic signed [VW-1:0]        wide_t;
  typedef logic signed [RES_WIDTH-1:0] res_t;
  typedef enum logic [0:0] {StLoad, StOut} state_e;

  localparam wide_t SAT_HI = wide_t'((2 ** (RES_WIDTH - 1)) - 1);
  localparam wide_t SAT_LO = wide_t'(-(2 ** (RES_WIDTH - 1)));

  function automatic void idct_h(input hor_t a0, input hor_t a1, input hor_t a2,
                                 input hor_t a3, output hor_t d0, output hor_t d1,
                                 output hor_t d2, output hor_t d3);
    hor_t e0, e1, e2, e3;
    e0 = a0 + a2;
    e1 = a0 - a2;
    e2 = (a1 >>> 1) - a3;
    e3 = a1 + (a3 >>> 1);
    d0 = e0 + e3;
    d1 = e1 + e2;
    d2 = e1 - e2;
    d3 = e0 - e3;
  endfunction

  function automatic void idct_v(input wide_t a0, input wide_t a1, input wide_t a2,
                                 input wide_t a3, output wide_t d0, output wide_t d1,
                                 output wide_t d2, output wide_t d3);
    wide_t e0, e1, e2, e3;
    e0 = a0 + a2;
    e1 = a0 - a2;
    e2 = (a1 >>> 1) - a3;
    e3 = a1 + (a3 >>> 1);
    d0 = e0 + e3;
    d1 = e1 + e2;
    d2 = e1 - e2;
    d3 = e0 - e3;
  endfunction

  function automatic res_t round_sat(input wide_t v);
    wide_t r;
    r = (v + wide_t'(32)) >>> 6;
    if (r > SAT_HI) begin
      r = SAT_HI;
    end else if (r < SAT_LO) begin
      r = SAT_LO;
    end
    return r[RES_WIDTH-1:0];
  endfunction

  state_e     state_q;
  logic [1:0] row_cnt_q;
  logic [1:0] col_q;
  res_t       out_r_q [4];
  hor_t       buf_q   [4][4];
  hor_t       buf_d   [4][4];

  logic       row_acc;
  logic       out_acc;
  logic [1:0] col_nxt;
  hor_t       ha [4];
  hor_t       hd [4];
  wide_t      va [4];
  wide_t      vd [4];
  res_t       res_d [4];

  always_comb begin
    row_acc = (state_q == StLoad) & bus.in_valid_i & ~clear_i;
    out_acc = (state_q == StOut) & bus.out_ready_i & ~clear_i;

    ha[0] = {{EXT_C{bus.in_c0_i[COEF_WIDTH-1]}}, bus.in_c0_i};
    ha[1] = {{EXT_C{bus.in_c1_i[COEF_WIDTH-1]}}, bus.in_c1_i};
    ha[2] = {{EXT_C{bus.in_c2_i[COEF_WIDTH-1]}}, bus.in_c2_i};
    ha[3] = {{EXT_C{bus.in_c3_i[COEF_WIDTH-1]}}, bus.in_c3_i};
    idct_h(ha[0], ha[1], ha[2], ha[3], hd[0], hd[1], hd[2], hd[3]);

    buf_d = buf_q;
    if (row_acc) begin
      for (int j = 0; j < 4; j++) begin
        buf_d[row_cnt_q][j] = hd[j];
      end
    end

    // Vertical pass reads the post-write buffer so row 3 feeds column 0 with one-cycle latency.
    col_nxt = row_acc ? 2'd0 : col_q + 2'd1;
    for (int k = 0; k < 4; k++) begin
      va[k] = {{EXT_H{buf_d[k][col_nxt][HW-1]}}, buf_d[k][col_nxt]};
    end
    idct_v(va[0], va[1], va[2], va[3], vd[0], vd[1], vd[2], vd[3]);
    for (int k = 0; k < 4; k++) begin
      res_d[k] = round_sat(vd[k]);
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StLoad;
      row_cnt_q <= 2'd0;
      col_q     <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        out_r_q[k] <= '0;
      end
    end else if (clear_i) begin
      state_q   <= StLoad;
      row_cnt_q <= 2'd0;
      col_q     <= 2'd0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (row_acc) begin
            row_cnt_q <= row_cnt_q + 2'd1;
            if (row_cnt_q == 2'd3) begin
              state_q <= StOut;
              col_q   <= 2'd0;
              out_r_q <= res_d;
            end
          end
        end
        StOut: begin
          if (out_acc) begin
            if (col_q == 2'd3) begin
              state_q   <= StLoad;
              row_cnt_q <= 2'd0;
            end else begin
              col_q   <= col_nxt;
              out_r_q <= res_d;
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign bus.in_ready_o  = (state_q == StLoad);
  assign bus.out_valid_o = (state_q == StOut);
  assign bus.out_col_o   = col_q;
  assign bus.out_r0_o    = out_r_q[0];
  assign bus.out_r1_o    = out_r_q[1];
  assign bus.out_r2_o    = out_r_q[2];
  assign bus.out_r3_o    = out_r_q[3];

endmodule
